// File: rtl/data_table_pkg.sv
// ---------------------------------------------------------------------------
// data_table_pkg
// Shared types and helpers for the data-table RAM controller.
//   - state_t / CLEAR / READY : clear-sequencer FSM encoding
//   - be_width()              : number of byte lanes, ceil(data_width/byte_size)
//   - lane_mask_bit()         : one bit of the per-bit write mask derived from
//                               the byte-lane enables; used in a generate loop
//                               to build a full DATA_WIDTH mask
// ---------------------------------------------------------------------------
package data_table_pkg;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t READY = 1'b1;

  // Widest supported word (288 bits) split into the smallest lane (8 bits).
  localparam int MAX_BE_WIDTH = 36;

  function automatic int be_width(input int data_width, input int byte_size);
    return (data_width + byte_size - 1) / byte_size;
  endfunction

  // Bit bit_idx of the data word belongs to lane bit_idx/byte_size; the top
  // lane may be partial, so callers only ask for bits below DATA_WIDTH.
  function automatic logic lane_mask_bit(input logic [MAX_BE_WIDTH-1:0] be,
                                         input int bit_idx,
                                         input int byte_size);
    return be[bit_idx / byte_size];
  endfunction

endpackage

// File: rtl/data_table_ram_core.sv
// ---------------------------------------------------------------------------
// data_table_ram_core
// Plain RAM array: one write port with byte-lane enables, one read port with
// a registered (1-cycle) read. No reset, so it maps onto block RAM. On a
// same-address read/write the read returns the old contents; the controller
// above handles forwarding.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wbe    in  byte-lane enables
//   wdata  in  write data
//   re     in  read enable (rdata only changes when re = 1)
//   raddr  in  read address
//   rdata  out registered read data
// ---------------------------------------------------------------------------
module data_table_ram_core
  import data_table_pkg::*;
#(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 9,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                                       clk,
  input  logic                                       we,
  input  logic [ADDR_WIDTH-1:0]                      waddr,
  input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]                      wdata,
  input  logic                                       re,
  input  logic [ADDR_WIDTH-1:0]                      raddr,
  output logic [DATA_WIDTH-1:0]                      rdata
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [MAX_BE_WIDTH-1:0] be_pad;
  logic [DATA_WIDTH-1:0]   wmask;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    be_pad               = '0;
    be_pad[BE_WIDTH-1:0] = wbe;
  end

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_mask
    assign wmask[b] = lane_mask_bit(be_pad, b, BYTE_SIZE);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (wmask[b]) mem[waddr][b] <= wdata[b];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_table_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_table_ram_ctrl
// Single-clock data-table RAM with a clear sequencer, byte-lane writes,
// write-first forwarding and a selectable read latency (1 or 2 cycles).
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clr_req  in  pulse: start a clear sequence (honoured only when ready)
//   busy     out high while the clear sequence runs
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_be    in  byte-lane enables
//   wr_data  in  write data
//   rd_en    in  read request
//   rd_addr  in  read address
//   rd_valid out rd_data valid this cycle
//   rd_data  out read data, holds its value between valid cycles
// ---------------------------------------------------------------------------
module data_table_ram_ctrl
  import data_table_pkg::*;
#(
  parameter int                   DATA_WIDTH   = 38,
  parameter int                   ADDR_WIDTH   = 9,
  parameter int                   BYTE_SIZE    = 8,
  parameter int                   OUTPUT_REG   = 0,
  parameter bit                   CLEAR_ON_RST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL     = '0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clr_req,
  output logic                                       busy,
  input  logic                                       wr_en,
  input  logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  input  logic                                       rd_en,
  input  logic [ADDR_WIDTH-1:0]                      rd_addr,
  output logic                                       rd_valid,
  output logic [DATA_WIDTH-1:0]                      rd_data
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_addr_q, clr_addr_d;
  logic                  clearing;
  logic                  user_wr;
  logic                  user_rd;

  logic [MAX_BE_WIDTH-1:0] be_pad;
  logic [DATA_WIDTH-1:0]   wr_mask;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [BE_WIDTH-1:0]   mem_wbe;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  vld_p1_q;
  logic [DATA_WIDTH-1:0] fwd_mask_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [DATA_WIDTH-1:0] rd_merged;

  assign clearing = (state_q == CLEAR);
  assign busy     = clearing;

  // User traffic is dropped outright while clearing; a write with no lanes
  // enabled is not a write at all.
  assign user_wr = !clearing && wr_en && (|wr_be);
  assign user_rd = !clearing && rd_en;

  always_comb begin
    be_pad               = '0;
    be_pad[BE_WIDTH-1:0] = wr_be;
  end

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_mask
    assign wr_mask[b] = lane_mask_bit(be_pad, b, BYTE_SIZE);
  end

  // Clear sequencer. clr_req in READY does not block the user write of the
  // same cycle; clr_req while clearing is ignored.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == CLR_LAST) state_d = READY;
    end else if (clr_req) begin
      state_d    = CLEAR;
      clr_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RST ? CLEAR : READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear writes own the write port for the whole sequence.
  assign mem_we    = clearing || user_wr;
  assign mem_waddr = clearing ? clr_addr_q[ADDR_WIDTH-1:0] : wr_addr;
  assign mem_wbe   = clearing ? {BE_WIDTH{1'b1}} : wr_be;
  assign mem_wdata = clearing ? CLR_VAL : wr_data;

  data_table_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTE_SIZE  (BYTE_SIZE)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wbe   (mem_wbe),
    .wdata (mem_wdata),
    .re    (user_rd),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // ---- stage p0 -> p1: RAM read and forwarding capture ----
  // The forwarding registers only load on a read so that the merged word
  // stays stable (and rd_data holds) between reads.
  always_ff @(posedge clk) begin
    if (user_rd) begin
      fwd_mask_q <= (user_wr && (wr_addr == rd_addr)) ? wr_mask : '0;
      fwd_data_q <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= user_rd;
  end

  // Write-first: enabled lanes of a colliding write replace the old word.
  assign rd_merged = (mem_rdata & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  vld_p2_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // ---- stage p1 -> p2: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q  <= 1'b0;
        rd_data_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) rd_data_q <= rd_merged;
      end
    end

    assign rd_valid = vld_p2_q;
    assign rd_data  = rd_data_q;
  end else begin : g_noreg
    // The RAM output register has no reset; present zero until the first
    // read after reset has delivered data.
    logic seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        seen_q <= 1'b0;
      else if (vld_p1_q) seen_q <= 1'b1;
    end

    assign rd_valid = vld_p1_q;
    assign rd_data  = (vld_p1_q || seen_q) ? rd_merged : '0;
  end

endmodule

// File: tb/tb_data_table_ram_ctrl.sv
module tb_data_table_ram_ctrl;

  localparam int DW = 38;
  localparam int AW = 9;
  localparam int BEW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BEW-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy1, busy2, rv1, rv2;
  logic [DW-1:0] rd1, rd2;

  always #5 clk = ~clk;

  data_table_ram_ctrl #(.OUTPUT_REG(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv1), .rd_data(rd1)
  );

  data_table_ram_ctrl #(.OUTPUT_REG(1)) u_l2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv2), .rd_data(rd2)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] model [512];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  int            vecs = 0;
  int            errs = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last1 = '0;
    end else if (rv1) begin
      vecs++;
      if (q1.size() == 0) begin
        errs++;
        $display("FAIL l1_spurious_valid got=%h cyc=%0d", rd1, cyc);
      end else begin
        e = q1.pop_front();
        if (rd1 !== e.d || cyc != e.due) begin
          errs++;
          $display("FAIL l1_read got=%h cyc=%0d required=%h cyc=%0d", rd1, cyc, e.d, e.due);
        end
      end
      last1 = rd1;
    end else begin
      vecs++;
      if (rd1 !== last1) begin
        errs++;
        $display("FAIL l1_hold got=%h required=%h cyc=%0d", rd1, last1, cyc);
      end
    end
  end

  // Latency-2 instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last2 = '0;
    end else if (rv2) begin
      vecs++;
      if (q2.size() == 0) begin
        errs++;
        $display("FAIL l2_spurious_valid got=%h cyc=%0d", rd2, cyc);
      end else begin
        e = q2.pop_front();
        if (rd2 !== e.d || cyc != e.due) begin
          errs++;
          $display("FAIL l2_read got=%h cyc=%0d required=%h cyc=%0d", rd2, cyc, e.d, e.due);
        end
      end
      last2 = rd2;
    end else begin
      vecs++;
      if (rd2 !== last2) begin
        errs++;
        $display("FAIL l2_hold got=%h required=%h cyc=%0d", rd2, last2, cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  // One clock of stimulus. 'ready' says whether the bench expects the DUT to
  // accept the traffic; if so the model is updated (write first, then read,
  // giving write-first semantics) and the expected read is queued.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [BEW-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic cr, input bit ready, input bit use_k,
                      input logic [DW-1:0] k);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_req = cr;
    if (ready && we) begin
      for (int b = 0; b < DW; b++) begin
        if (be[b/8]) model[wa][b] = wd[b];
      end
    end
    if (ready && re) begin
      e.d = use_k ? k : model[ra];
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_clear(input int limit, output int n1, output int n2);
    int n;
    n = 0; n1 = 0; n2 = 0;
    while ((busy1 || busy2) && n < limit) begin
      if (busy1) n1++;
      if (busy2) n2++;
      idle();
      n++;
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 512; i++) model[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n1, n2, n;
    zero_model();

    // Reset state.
    @(posedge clk); #1;
    chk("rst_rd_valid_l1", 64'(rv1), 64'd0);
    chk("rst_rd_valid_l2", 64'(rv2), 64'd0);
    chk("rst_rd_data_l1", 64'(rd1), 64'd0);
    chk("rst_rd_data_l2", 64'(rd2), 64'd0);
    chk("rst_busy_l1", 64'(busy1), 64'd1);
    chk("rst_busy_l2", 64'(busy2), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: automatic clear lasts exactly 512 cycles, then every word is zero.
    wait_clear(1000, n1, n2);
    chk("clr_cycles_l1", 64'(n1), 64'd512);
    chk("clr_cycles_l2", 64'(n2), 64'd512);
    for (int k = 0; k < 512; k++)
      step(1'b0, '0, '0, '0, 1'b1, AW'(k), 1'b0, 1'b1, 1'b1, 38'h0);

    // 3: partial-lane write into a zero word.
    step(1'b1, 9'd7, 5'b00101, 38'h3F_FFFF_FFFF, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd7, 1'b0, 1'b1, 1'b1, 38'h00_00FF_00FF);

    // 4: same-cycle write/read, full and partial lanes, then different addresses.
    step(1'b1, 9'd9, 5'h1F, 38'h12_3456_789A, 1'b1, 9'd9, 1'b0, 1'b1, 1'b1, 38'h12_3456_789A);
    step(1'b1, 9'd9, 5'b10010, 38'h3F_FFFF_FFFF, 1'b1, 9'd9, 1'b0, 1'b1, 1'b1, 38'h3F_3456_FF9A);
    step(1'b1, 9'd10, 5'h1F, 38'h01_0203_0405, 1'b1, 9'd9, 1'b0, 1'b1, 1'b1, 38'h3F_3456_FF9A);
    step(1'b1, 9'd11, 5'h00, 38'h3F_FFFF_FFFF, 1'b1, 9'd10, 1'b0, 1'b1, 1'b1, 38'h01_0203_0405);
    step(1'b0, '0, '0, '0, 1'b1, 9'd11, 1'b0, 1'b1, 1'b1, 38'h0);

    // 2: fill and read back the whole table.
    for (int k = 0; k < 512; k++)
      step(1'b1, AW'(k), 5'h1F, 38'h3F_FFFF_FFFF - 38'(k), 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 512; k++)
      step(1'b0, '0, '0, '0, 1'b1, AW'(k), 1'b0, 1'b1, 1'b1, 38'h3F_FFFF_FFFF - 38'(k));

    // 5: clear request in the middle of traffic.
    step(1'b1, 9'd30, 5'h1F, 38'h2A_0000_0001, 1'b1, 9'd100, 1'b0, 1'b1, 1'b1, 38'h3F_FFFF_FF9B);
    chk("busy_before_clr", 64'(busy1), 64'd0);
    step(1'b1, 9'd20, 5'h1F, 38'h0A_5A5A_5A5A, 1'b1, 9'd20, 1'b1, 1'b1, 1'b1, 38'h0A_5A5A_5A5A);
    chk("busy_rise_l1", 64'(busy1), 64'd1);
    chk("busy_rise_l2", 64'(busy2), 64'd1);
    n = 0; n1 = 0; n2 = 0;
    while ((busy1 || busy2) && n < 1000) begin
      if (busy1) n1++;
      if (busy2) n2++;
      if (n == 100)
        step(1'b1, 9'd5, 5'h1F, 38'h15, 1'b1, 9'd5, 1'b1, 1'b0, 1'b0, '0);
      else if (n == 300)
        step(1'b0, '0, '0, '0, 1'b1, 9'd30, 1'b0, 1'b0, 1'b0, '0);
      else if (n == 511)
        step(1'b1, 9'd3, 5'h1F, 38'h2A_AAAA_AAAA, 1'b1, 9'd3, 1'b0, 1'b0, 1'b0, '0);
      else
        idle();
      n++;
    end
    chk("clr_req_cycles_l1", 64'(n1), 64'd512);
    chk("clr_req_cycles_l2", 64'(n2), 64'd512);
    zero_model();
    step(1'b0, '0, '0, '0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 38'h0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd5, 1'b0, 1'b1, 1'b1, 38'h0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd20, 1'b0, 1'b1, 1'b1, 38'h0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd30, 1'b0, 1'b1, 1'b1, 38'h0);

    // 6: reset during a pending read, then again at clear cycle 100.
    step(1'b1, 9'd400, 5'h1F, 38'h11_2233_4455, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 9'd10, 5'h1F, 38'h22_3344_5566, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) idle();
    step(1'b0, '0, '0, '0, 1'b1, 9'd400, 1'b0, 1'b1, 1'b1, 38'h11_2233_4455);
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    chk("rst_kill_valid_l1", 64'(rv1), 64'd0);
    chk("rst_kill_valid_l2", 64'(rv2), 64'd0);
    chk("rst_kill_data_l1", 64'(rd1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear(100, n1, n2);
    chk("partial_clr_l1", 64'(n1), 64'd100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clr_busy", 64'(busy1), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear(1000, n1, n2);
    chk("reclr_cycles_l1", 64'(n1), 64'd512);
    chk("reclr_cycles_l2", 64'(n2), 64'd512);
    zero_model();
    step(1'b0, '0, '0, '0, 1'b1, 9'd400, 1'b0, 1'b1, 1'b1, 38'h0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd10, 1'b0, 1'b1, 1'b1, 38'h0);
    step(1'b0, '0, '0, '0, 1'b1, 9'd511, 1'b0, 1'b1, 1'b1, 38'h0);

    repeat (4) idle();
    chk("drain_l1", 64'(q1.size()), 64'd0);
    chk("drain_l2", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
